// File: rtl/radix_2_ntt_ctrl.sv
// Radix-2 NTT address/sequencing controller: per stage it issues L/2 butterfly reads, drains PE_LAT cycles,
// and mirrors reads as writes PE_LAT cycles later. Optional cycle counter under RADIX_2_NTT_CTRL_PERF_CNT_EN.
module radix_2_ntt_ctrl #(
  parameter int LOGL   = 4,
  parameter int PE_LAT = 2
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     start,
  output logic                                     rd_en,
  output logic [LOGL-1:0]                          rd_addr_a,
  output logic [LOGL-1:0]                          rd_addr_b,
  output logic [LOGL-2:0]                          tf_addr,
  output logic                                     wr_en,
  output logic [LOGL-1:0]                          wr_addr_a,
  output logic [LOGL-1:0]                          wr_addr_b,
  output logic [(($clog2(LOGL) < 1) ? 1 : $clog2(LOGL))-1:0] stage,
  output logic                                     busy,
  output logic                                     done
`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
  ,
  output logic [15:0]                              cyc_cnt
`endif
);

  localparam int KW = LOGL - 1;
  localparam int SW = ($clog2(LOGL) < 1) ? 1 : $clog2(LOGL);
  localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;
  localparam logic [KW-1:0] KMAX = {KW{1'b1}};
  localparam logic [SW-1:0] SMAX = SW'(LOGL - 1);
  localparam logic [DW-1:0] DMAX = DW'(PE_LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t          state_q;
  logic [KW-1:0]   k_q;
  logic [SW-1:0]   stage_q;
  logic [DW-1:0]   drn_q;
  logic            rd_en_q;
  logic [LOGL-1:0] rda_q;
  logic [LOGL-1:0] rdb_q;
  logic [KW-1:0]   tf_q;
  logic            busy_q;
  logic            done_q;

  logic            wen_q [PE_LAT];
  logic [LOGL-1:0] wa_q  [PE_LAT];
  logic [LOGL-1:0] wb_q  [PE_LAT];

  // a = g*2h + j with g = k>>s, j = k & (h-1)
  function automatic logic [LOGL-1:0] addr_a_f(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [LOGL-1:0] kx;
    logic [LOGL-1:0] mask;
    kx   = LOGL'(k);
    mask = (LOGL'(1) << s) - LOGL'(1);
    return ((kx >> s) << (int'(s) + 1)) | (kx & mask);
  endfunction

  function automatic logic [LOGL-1:0] addr_b_f(input logic [SW-1:0] s, input logic [KW-1:0] k);
    return addr_a_f(s, k) + (LOGL'(1) << s);
  endfunction

  function automatic logic [KW-1:0] tf_f(input logic [SW-1:0] s, input logic [KW-1:0] k);
    logic [LOGL-1:0] j;
    logic [LOGL-1:0] sh;
    j  = LOGL'(k) & ((LOGL'(1) << s) - LOGL'(1));
    sh = j << (LOGL - 1 - int'(s));
    return sh[KW-1:0];
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      drn_q   <= '0;
      rd_en_q <= 1'b0;
      rda_q   <= '0;
      rdb_q   <= '0;
      tf_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_en_q <= 1'b0;
          rda_q   <= '0;
          rdb_q   <= '0;
          tf_q    <= '0;
          if (start) begin
            state_q <= RUN;
            k_q     <= '0;
            stage_q <= '0;
            busy_q  <= 1'b1;
            rd_en_q <= 1'b1;
            rda_q   <= addr_a_f('0, '0);
            rdb_q   <= addr_b_f('0, '0);
            tf_q    <= tf_f('0, '0);
          end
        end
        RUN: begin
          if (k_q == KMAX) begin
            state_q <= DRAIN;
            drn_q   <= '0;
            rd_en_q <= 1'b0;
            rda_q   <= '0;
            rdb_q   <= '0;
            tf_q    <= '0;
          end else begin
            k_q     <= k_q + KW'(1);
            rd_en_q <= 1'b1;
            rda_q   <= addr_a_f(stage_q, k_q + KW'(1));
            rdb_q   <= addr_b_f(stage_q, k_q + KW'(1));
            tf_q    <= tf_f(stage_q, k_q + KW'(1));
          end
        end
        DRAIN: begin
          // Next stage reads start only after the last write of this stage has landed
          if (drn_q == DMAX) begin
            if (stage_q == SMAX) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              stage_q <= stage_q + SW'(1);
              k_q     <= '0;
              rd_en_q <= 1'b1;
              rda_q   <= addr_a_f(stage_q + SW'(1), '0);
              rdb_q   <= addr_b_f(stage_q + SW'(1), '0);
              tf_q    <= tf_f(stage_q + SW'(1), '0);
            end
          end else begin
            drn_q <= drn_q + DW'(1);
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PE_LAT; i++) begin
        wen_q[i] <= 1'b0;
        wa_q[i]  <= '0;
        wb_q[i]  <= '0;
      end
    end else begin
      wen_q[0] <= rd_en_q;
      wa_q[0]  <= rda_q;
      wb_q[0]  <= rdb_q;
      for (int i = 1; i < PE_LAT; i++) begin
        wen_q[i] <= wen_q[i-1];
        wa_q[i]  <= wa_q[i-1];
        wb_q[i]  <= wb_q[i-1];
      end
    end
  end

`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
  logic [15:0] cyc_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc_q <= '0;
    end else if (state_q == IDLE && start) begin
      cyc_q <= '0;
    end else if (busy_q && cyc_q != 16'hFFFF) begin
      cyc_q <= cyc_q + 16'd1;
    end
  end

  assign cyc_cnt = cyc_q;
`endif

  assign rd_en     = rd_en_q;
  assign rd_addr_a = rda_q;
  assign rd_addr_b = rdb_q;
  assign tf_addr   = tf_q;
  assign wr_en     = wen_q[PE_LAT-1];
  assign wr_addr_a = wa_q[PE_LAT-1];
  assign wr_addr_b = wb_q[PE_LAT-1];
  assign stage     = stage_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_radix_2_ntt_ctrl.sv
// Directed bench for radix_2_ntt_ctrl at default parameters (LOGL=4, PE_LAT=2).
module tb_radix_2_ntt_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       rd_en;
  logic [3:0] rd_addr_a;
  logic [3:0] rd_addr_b;
  logic [2:0] tf_addr;
  logic       wr_en;
  logic [3:0] wr_addr_a;
  logic [3:0] wr_addr_b;
  logic [1:0] stage;
  logic       busy;
  logic       done;
`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
  logic [15:0] cyc_cnt;
`endif

  radix_2_ntt_ctrl #(.LOGL(4), .PE_LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tf_addr   (tf_addr),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b),
    .stage     (stage),
    .busy      (busy),
    .done      (done)
`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
    ,
    .cyc_cnt   (cyc_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int exp_rd [64];
  int exp_a  [64];
  int exp_b  [64];
  int exp_tf [64];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rd_en"}, rd_en, 0);
    check({tag, "_rd_a"}, rd_addr_a, 0);
    check({tag, "_rd_b"}, rd_addr_b, 0);
    check({tag, "_tf"}, tf_addr, 0);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_wr_a"}, wr_addr_a, 0);
    check({tag, "_wr_b"}, wr_addr_b, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
    check({tag, "_cyc_cnt"}, cyc_cnt, 0);
`endif
  endtask

  // Waits at negedges for done, counting busy cycles seen along the way.
  task automatic wait_done(output int bcyc, output bit seen);
    bcyc = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (busy) bcyc++;
      if (done) seen = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  c, n_rd, n_wr, n_busy, n_done, bcyc;
    bit  seen;

    // Expected read schedule: stage s starts at cycle 1 + 10*s; butterflies enumerated group-major
    for (int i = 0; i < 64; i++) begin
      exp_rd[i] = 0; exp_a[i] = 0; exp_b[i] = 0; exp_tf[i] = 0;
    end
    for (int s = 0; s < 4; s++) begin
      int h;
      h = 1 << s;
      c = 1 + s * 10;
      for (int g = 0; g < (8 >> s); g++) begin
        for (int j = 0; j < h; j++) begin
          exp_rd[c] = 1;
          exp_a[c]  = g * 2 * h + j;
          exp_b[c]  = g * 2 * h + j + h;
          exp_tf[c] = j * (8 >> s);
          c++;
        end
      end
    end

    rst   = 1'b1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;

    // Full transform with per-cycle comparison against the schedule
    @(negedge clk);
    start = 1'b1;
    n_rd = 0; n_wr = 0; n_busy = 0; n_done = 0;
    for (int cy = 1; cy <= 45; cy++) begin
      int ew, ewa, ewb;
      @(negedge clk);
      if (cy == 1) start = 1'b0;
      ew  = (cy >= 3) ? exp_rd[cy-2] : 0;
      ewa = (cy >= 3) ? exp_a[cy-2]  : 0;
      ewb = (cy >= 3) ? exp_b[cy-2]  : 0;
      check($sformatf("rd_en@%0d", cy), rd_en, exp_rd[cy]);
      check($sformatf("rd_a@%0d", cy), rd_addr_a, exp_a[cy]);
      check($sformatf("rd_b@%0d", cy), rd_addr_b, exp_b[cy]);
      check($sformatf("tf@%0d", cy), tf_addr, exp_tf[cy]);
      check($sformatf("wr_en@%0d", cy), wr_en, ew);
      check($sformatf("wr_a@%0d", cy), wr_addr_a, ewa);
      check($sformatf("wr_b@%0d", cy), wr_addr_b, ewb);
      check($sformatf("busy@%0d", cy), busy, (cy <= 40) ? 1 : 0);
      check($sformatf("done@%0d", cy), done, (cy == 41) ? 1 : 0);
      check($sformatf("stage@%0d", cy), stage, (cy <= 40) ? (cy - 1) / 10 : 3);
      if (cy == 1) begin
        check("c1_a", rd_addr_a, 0); check("c1_b", rd_addr_b, 1); check("c1_tf", tf_addr, 0);
      end
      if (cy == 2) begin
        check("c2_a", rd_addr_a, 2); check("c2_b", rd_addr_b, 3); check("c2_tf", tf_addr, 0);
      end
      if (cy == 3) begin
        check("c3_wr_en", wr_en, 1); check("c3_wr_a", wr_addr_a, 0); check("c3_wr_b", wr_addr_b, 1);
      end
      if (cy == 12) begin
        check("s1k1_a", rd_addr_a, 1); check("s1k1_b", rd_addr_b, 3); check("s1k1_tf", tf_addr, 4);
      end
      if (cy == 38) begin
        check("s3k7_a", rd_addr_a, 7); check("s3k7_b", rd_addr_b, 15); check("s3k7_tf", tf_addr, 7);
      end
`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
      if (cy == 41) check("cyc_cnt_done", cyc_cnt, 40);
      if (cy == 45) check("cyc_cnt_held", cyc_cnt, 40);
`endif
      n_rd   += rd_en;
      n_wr   += wr_en;
      n_busy += busy;
      n_done += done;
    end
    check("n_rd", n_rd, 32);
    check("n_wr", n_wr, 32);
    check("n_busy", n_busy, 40);
    check("n_done", n_done, 1);

    // start held high: one transform, DONE ignores start, restart from IDLE
    @(negedge clk);
    start = 1'b1;
    n_busy = 0; n_done = 0;
    for (int cy = 1; cy <= 42; cy++) begin
      @(negedge clk);
      n_busy += busy;
      n_done += done;
      if (cy == 41) check("held_done41", done, 1);
      if (cy == 42) check("held_busy42", busy, 0);
    end
    check("held_n_busy", n_busy, 40);
    check("held_n_done", n_done, 1);
    @(negedge clk);
    check("held_restart_busy", busy, 1);
    check("held_restart_stage", stage, 0);
    check("held_restart_rd_a", rd_addr_a, 0);
    start = 1'b0;
    wait_done(bcyc, seen);
    check("held_second_done", seen, 1);
    check("held_second_busy", bcyc, 39);

    // Reset mid-transform at cycle 15
    @(negedge clk);
    start = 1'b1;
    for (int cy = 1; cy <= 14; cy++) begin
      @(negedge clk);
      if (cy == 1) start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    check_all_zero("midrst_hold");
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("postrst_busy", busy, 1);
    check("postrst_rd_en", rd_en, 1);
    check("postrst_done", done, 0);
    wait_done(bcyc, seen);
    check("postrst_seen_done", seen, 1);
    check("postrst_busy_cycles", bcyc, 39);
`ifdef RADIX_2_NTT_CTRL_PERF_CNT_EN
    check("postrst_cyc_cnt", cyc_cnt, 40);
`endif
    @(negedge clk);
    check("postrst_idle_busy", busy, 0);
    check("postrst_idle_done", done, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
